// File: rtl/vector_lane_sequencer_if.sv
// Bus interface for vector_lane_sequencer.
// The slave modport is the sequencer itself: it takes the vector request
// from ID plus the shared ALU result, and drives the stall, status, ALU
// lane controls and the assembled vector result.
// Optional feature macro: VSEQ_LANE_MASK_EN adds the per-lane issue mask.
interface vector_lane_sequencer_if #(
    parameter int LANES      = 4,
    parameter int LANE_W     = 8,
    parameter int LANE_IDX_W = 2
);
    // request side
    logic                    start;
    logic [4:0]              Opcode;
    logic [LANES*LANE_W-1:0] OperandA;
    logic [LANES*LANE_W-1:0] OperandB;
    logic [LANE_W-1:0]       Immediate;
`ifdef VSEQ_LANE_MASK_EN
    logic [LANES-1:0]        lane_mask;
`endif
    // shared ALU side
    logic [LANE_W-1:0]       alu_result;
    logic [3:0]              alu_code;
    logic [LANE_W-1:0]       alu_a;
    logic [LANE_W-1:0]       alu_b;
    logic [LANE_IDX_W-1:0]   lane_sel;
    // status and result
    logic                    busy;
    logic                    done;
    logic                    illegal;
    logic [LANES*LANE_W-1:0] result;

    // requester / ALU owner view
    modport master (
`ifdef VSEQ_LANE_MASK_EN
        output lane_mask,
`endif
        output start, Opcode, OperandA, OperandB, Immediate, alu_result,
        input  busy, done, illegal, lane_sel, alu_code, alu_a, alu_b, result
    );

    // sequencer view
    modport slave (
`ifdef VSEQ_LANE_MASK_EN
        input  lane_mask,
`endif
        input  start, Opcode, OperandA, OperandB, Immediate, alu_result,
        output busy, done, illegal, lane_sel, alu_code, alu_a, alu_b, result
    );
endinterface

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer
// Multi-cycle sequencer for the 11xxx vector opcodes. One accepted request
// is split into lanes; each RUN cycle presents one lane to the shared scalar
// ALU and captures its combinational result into that lane of the output.
// busy stalls the pipeline from the first RUN cycle through DONE.
// Optional feature macro: VSEQ_LANE_MASK_EN (per-lane issue mask; lanes with
// a zero mask bit are not issued and return their OperandA slice unchanged).
module vector_lane_sequencer #(
    parameter int LANES      = 4,
    parameter int LANE_W     = 8,
    parameter int LANE_IDX_W = 2
) (
    input logic                  clk,
    input logic                  reset,
    vector_lane_sequencer_if.slave bus
);
    localparam int VEC_W = LANES * LANE_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_reg;
    logic [VEC_W-1:0]      a_reg;
    logic [VEC_W-1:0]      b_reg;
    logic [LANE_W-1:0]     imm_reg;
    logic [3:0]            code_reg;
    logic                  use_imm_reg;
    logic [LANES-1:0]      mask_reg;
    logic [LANE_IDX_W-1:0] lane_reg;
    logic                  illegal_reg;
    logic [LANE_W-1:0]     res_reg [LANES];

    logic [LANE_W-1:0]     a_lane    [LANES];
    logic [LANE_W-1:0]     b_lane    [LANES];
    logic [LANE_W-1:0]     init_lane [LANES];
    logic [LANES-1:0]      start_mask;
    logic [LANE_IDX_W-1:0] first_lane;
    logic                  any_lane;
    logic [LANE_IDX_W-1:0] next_lane;
    logic                  has_next;
    logic                  in_run;
    logic                  is_vector_op;
    logic [VEC_W-1:0]      result_vec;

    // Opcode low bits to shared-ALU function code.
    function automatic logic [3:0] code_of(input logic [2:0] op);
        case (op)
            3'b000:  return 4'b0011;   // ADDV
            3'b001:  return 4'b0011;   // ADDVI
            3'b010:  return 4'b0010;   // XORV
            3'b011:  return 4'b1010;   // SLLV
            3'b100:  return 4'b1001;   // SRLV
            3'b101:  return 4'b1011;   // SLLVC
            3'b110:  return 4'b1100;   // SRLVC
            default: return 4'b1000;   // MULTI
        endcase
    endfunction

    // Without the mask feature every lane is issued, so the same lane
    // search logic degenerates to a plain 0..LANES-1 walk.
`ifdef VSEQ_LANE_MASK_EN
    assign start_mask = bus.lane_mask;
`else
    assign start_mask = '1;
`endif

    assign is_vector_op = (bus.Opcode[4:3] == 2'b11);
    assign in_run       = (state_reg == RUN);

    // Per-lane views of the latched operands, and the value a lane starts
    // with on accept: zero for issued lanes, the A slice for skipped ones.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign a_lane[gi]    = a_reg[gi*LANE_W +: LANE_W];
        assign b_lane[gi]    = b_reg[gi*LANE_W +: LANE_W];
        assign init_lane[gi] = start_mask[gi] ? '0 : bus.OperandA[gi*LANE_W +: LANE_W];
    end

    // Lowest enabled lane of the incoming request.
    always_comb begin
        first_lane = '0;
        any_lane   = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (start_mask[i]) begin
                first_lane = LANE_IDX_W'(i);
                any_lane   = 1'b1;
            end
        end
    end

    // Next enabled lane above the one currently issued.
    always_comb begin
        next_lane = '0;
        has_next  = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_reg[i] && (i > int'(lane_reg))) begin
                next_lane = LANE_IDX_W'(i);
                has_next  = 1'b1;
            end
        end
    end

    // Sequencer state, operand latches and lane result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            imm_reg     <= '0;
            code_reg    <= '0;
            use_imm_reg <= 1'b0;
            mask_reg    <= '0;
            lane_reg    <= '0;
            illegal_reg <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                res_reg[i] <= '0;
            end
        end else begin
            illegal_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (is_vector_op) begin
                            a_reg       <= bus.OperandA;
                            b_reg       <= bus.OperandB;
                            imm_reg     <= bus.Immediate;
                            code_reg    <= code_of(bus.Opcode[2:0]);
                            use_imm_reg <= (bus.Opcode[2:0] == 3'b001) ||
                                           (bus.Opcode[2:0] == 3'b111);
                            mask_reg    <= start_mask;
                            lane_reg    <= first_lane;
                            for (int i = 0; i < LANES; i++) begin
                                res_reg[i] <= init_lane[i];
                            end
                            // an empty mask has nothing to issue
                            state_reg   <= any_lane ? RUN : DONE;
                        end else begin
                            illegal_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    res_reg[lane_reg] <= bus.alu_result;
                    if (has_next) begin
                        lane_reg <= next_lane;
                    end else begin
                        lane_reg  <= '0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Pack the lane results into the vector output.
    always_comb begin
        result_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            result_vec[i*LANE_W +: LANE_W] = res_reg[i];
        end
    end

    // Status and ALU drive; ALU controls are forced to zero outside RUN.
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.illegal  = illegal_reg;
    assign bus.result   = result_vec;
    assign bus.lane_sel = in_run ? lane_reg : '0;
    assign bus.alu_code = in_run ? code_reg : 4'b0000;
    assign bus.alu_a    = in_run ? a_lane[lane_reg] : '0;
    assign bus.alu_b    = in_run ? (use_imm_reg ? imm_reg : b_lane[lane_reg]) : '0;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Testbench for vector_lane_sequencer (LANES=4, LANE_W=8).
// Hosts a behavioural model of the shared ALU, a per-opcode reference model
// of the vector result, a directed table, hand-written corner sequences and
// a randomized run. Build with VSEQ_LANE_MASK_EN to exercise lane masking.
module tb_vector_lane_sequencer;
    localparam int LANES      = 4;
    localparam int LANE_W     = 8;
    localparam int LANE_IDX_W = 2;

    localparam int K_ADD = 0;
    localparam int K_XOR = 1;
    localparam int K_SLL = 2;
    localparam int K_SRL = 3;
    localparam int K_ROL = 4;
    localparam int K_ROR = 5;
    localparam int K_MUL = 6;
    localparam int K_BAD = 7;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    vector_lane_sequencer_if #(.LANES(LANES), .LANE_W(LANE_W), .LANE_IDX_W(LANE_IDX_W)) bus ();

    vector_lane_sequencer #(.LANES(LANES), .LANE_W(LANE_W), .LANE_IDX_W(LANE_IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Lane primitive used both by the ALU model and the reference model.
    function automatic logic [7:0] prim(input int kind, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] w;
        logic [2:0]  s;
        s = b[2:0];
        w = {a, a};
        case (kind)
            K_ADD: return 8'(a + b);
            K_XOR: return a ^ b;
            K_SLL: return 8'(a << s);
            K_SRL: return a >> s;
            K_ROL: begin w = w << s; return w[15:8]; end
            K_ROR: begin w = w >> s; return w[7:0]; end
            K_MUL: return 8'(a * b);
            default: return 8'hEE;
        endcase
    endfunction

    function automatic int kind_of_code(input logic [3:0] code);
        case (code)
            4'b0011: return K_ADD;
            4'b0010: return K_XOR;
            4'b1010: return K_SLL;
            4'b1001: return K_SRL;
            4'b1011: return K_ROL;
            4'b1100: return K_ROR;
            4'b1000: return K_MUL;
            default: return K_BAD;
        endcase
    endfunction

    function automatic int kind_of_op(input logic [4:0] op);
        case (op)
            5'b11000, 5'b11001: return K_ADD;
            5'b11010:           return K_XOR;
            5'b11011:           return K_SLL;
            5'b11100:           return K_SRL;
            5'b11101:           return K_ROL;
            5'b11110:           return K_ROR;
            default:            return K_MUL;
        endcase
    endfunction

    function automatic logic [3:0] exp_code(input logic [4:0] op);
        case (op)
            5'b11000, 5'b11001: return 4'b0011;
            5'b11010:           return 4'b0010;
            5'b11011:           return 4'b1010;
            5'b11100:           return 4'b1001;
            5'b11101:           return 4'b1011;
            5'b11110:           return 4'b1100;
            default:            return 4'b1000;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [4:0] op);
        return (op == 5'b11001) || (op == 5'b11111);
    endfunction

    // Reference vector result: issued lanes run the op, skipped lanes keep A.
    function automatic logic [31:0] model_result(input logic [4:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [7:0] imm,
                                                 input logic [3:0] mask);
        logic [31:0] r;
        logic [7:0]  bl;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            bl = uses_imm(op) ? imm : b[l*8 +: 8];
            r[l*8 +: 8] = mask[l] ? prim(kind_of_op(op), a[l*8 +: 8], bl) : a[l*8 +: 8];
        end
        return r;
    endfunction

    // Shared ALU model driven by the sequencer's lane outputs.
    always_comb bus.alu_result = prim(kind_of_code(bus.alu_code), bus.alu_a, bus.alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (txn %0d)", name, act, req, txn);
        end
    endtask

    // Issue one request and follow it cycle by cycle through DONE.
    // inject_at >= 0 pulses a second start during that RUN cycle.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] imm, input logic [3:0] mask, input int inject_at,
                          input logic [31:0] req);
        logic [3:0] m;
        int         run_idx;
        int         busy_cycles;
`ifdef VSEQ_LANE_MASK_EN
        m = mask;
`else
        m = 4'hF;
`endif
        txn++;
        @(negedge clk);
        bus.start = 1'b1; bus.Opcode = op; bus.OperandA = a; bus.OperandB = b; bus.Immediate = imm;
`ifdef VSEQ_LANE_MASK_EN
        bus.lane_mask = mask;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        run_idx = 0;
        busy_cycles = 0;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) begin
                check("run_busy", 32'(bus.busy), 32'd1);
                check("run_done", 32'(bus.done), 32'd0);
                check("lane_sel", 32'(bus.lane_sel), 32'(l));
                check("alu_code", 32'(bus.alu_code), 32'(exp_code(op)));
                check("alu_a", 32'(bus.alu_a), 32'(a[l*8 +: 8]));
                check("alu_b", 32'(bus.alu_b), 32'(uses_imm(op) ? imm : b[l*8 +: 8]));
                if (bus.busy) busy_cycles++;
                if (run_idx == inject_at) begin
                    bus.start = 1'b1; bus.Opcode = 5'b11000; bus.OperandA = ~a; bus.OperandB = ~b;
                end
                @(negedge clk);
                bus.start = 1'b0;
                run_idx++;
            end
        end
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_alu_code", 32'(bus.alu_code), 32'd0);
        check("result", bus.result, req);
        if (bus.busy) busy_cycles++;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("result_hold", bus.result, req);
        check("busy_cycles", 32'(busy_cycles), 32'($countones(m)) + 32'd1);
        last_exp = req;
        $display("txn %0d op=%b a=%h b=%h imm=%h mask=%b result=%h required=%h",
                 txn, op, a, b, imm, m, bus.result, req);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  imm;
        logic [31:0] res;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  imm;
        logic [3:0]  mask;
        int          saw_done;

        tbl[0] = '{5'b11000, 32'h01020304, 32'h10203040, 8'h00, 32'h11223344};
        tbl[1] = '{5'b11001, 32'hFF000102, 32'hDEADBEEF, 8'h05, 32'h04050607};
        tbl[2] = '{5'b11010, 32'hF0F00F0F, 32'hFF00FF00, 8'h00, 32'h0FF0F00F};
        tbl[3] = '{5'b11011, 32'h01020304, 32'h01010101, 8'h00, 32'h02040608};
        tbl[4] = '{5'b11100, 32'h80402010, 32'h04030201, 8'h00, 32'h08080808};
        tbl[5] = '{5'b11101, 32'h80818283, 32'h01010101, 8'h00, 32'h01030507};
        tbl[6] = '{5'b11110, 32'h01020304, 32'h01010101, 8'h00, 32'h80018102};
        tbl[7] = '{5'b11111, 32'h01020304, 32'h55555555, 8'h03, 32'h0306090C};

        reset = 1'b1;
        bus.start = 1'b0; bus.Opcode = '0; bus.OperandA = '0; bus.OperandB = '0; bus.Immediate = '0;
`ifdef VSEQ_LANE_MASK_EN
        bus.lane_mask = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_lane_sel", 32'(bus.lane_sel), 32'd0);
        check("rst_alu_code", 32'(bus.alu_code), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_result", bus.result, 32'd0);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, 4'hF, -1, tbl[i].res);
        end

        // non-vector opcodes: illegal pulse, no busy, result untouched
        for (int i = 0; i < 2; i++) begin
            txn++;
            @(negedge clk);
            bus.start = 1'b1; bus.Opcode = (i == 0) ? 5'b00000 : 5'b10111;
            bus.OperandA = 32'hAAAAAAAA;
            @(negedge clk);
            bus.start = 1'b0;
            check("illegal_pulse", 32'(bus.illegal), 32'd1);
            check("illegal_busy", 32'(bus.busy), 32'd0);
            check("illegal_result", bus.result, last_exp);
            @(negedge clk);
            check("illegal_clear", 32'(bus.illegal), 32'd0);
            check("illegal_busy2", 32'(bus.busy), 32'd0);
            $display("txn %0d illegal opcode=%b illegal_seen result=%h", txn, bus.Opcode, bus.result);
        end

        // start pulsed during lane 1 of XORV is ignored
        run_op(5'b11010, 32'h12345678, 32'hFFFF0000, 8'h00, 4'hF, 1, 32'hEDCB5678);
        @(negedge clk);
        check("ignored_start_busy", 32'(bus.busy), 32'd0);

        // reset during lane 2 of ADDV aborts it
        txn++;
        @(negedge clk);
        bus.start = 1'b1; bus.Opcode = 5'b11000; bus.OperandA = 32'h01020304; bus.OperandB = 32'h10203040;
`ifdef VSEQ_LANE_MASK_EN
        bus.lane_mask = 4'hF;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_lane", 32'(bus.lane_sel), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", bus.result, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) saw_done++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        $display("txn %0d reset abort result=%h", txn, bus.result);
        run_op(5'b11000, 32'h01020304, 32'h10203040, 8'h00, 4'hF, -1, 32'h11223344);

`ifdef VSEQ_LANE_MASK_EN
        run_op(5'b11000, 32'h01020304, 32'h10101010, 8'h00, 4'b0101, -1, 32'h01120314);
        run_op(5'b11010, 32'hCAFEBABE, 32'hFFFFFFFF, 8'h00, 4'b0000, -1, 32'hCAFEBABE);
        run_op(5'b11111, 32'h02030405, 32'h00000000, 8'h02, 4'b1000, -1, 32'h04030405);
`endif

        // randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            op   = {2'b11, 3'($urandom_range(0, 7))};
            a    = $urandom;
            b    = $urandom;
            imm  = 8'($urandom);
`ifdef VSEQ_LANE_MASK_EN
            mask = 4'($urandom);
`else
            mask = 4'hF;
`endif
            run_op(op, a, b, imm, mask, -1, model_result(op, a, b, imm, mask));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
